// File: rtl/mfp_ahb_lite_pkg.sv
// rtl/mfp_ahb_lite_pkg.sv - AHB-Lite constants, default-slave states and default address map
package mfp_ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // Five-slave map: boot ROM, RAM, reset ROM, GPIO, peripheral block (slot 0 in the low word)
    localparam int DEF_N_SLAVES = 5;
    localparam logic [DEF_N_SLAVES*32-1:0] DEF_ADDR_BASE = {
        32'h10402000, 32'h10401000, 32'h1F800000, 32'h00000000, 32'h1FC00000
    };
    localparam logic [DEF_N_SLAVES*32-1:0] DEF_ADDR_MASK = {
        32'h1FFFF000, 32'h1FFFF000, 32'h1FC00000, 32'h1C000000, 32'h1FC00000
    };

    function automatic logic htrans_active(input logic [1:0] htrans);
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_decoder_mux_if.sv
// rtl/mfp_ahb_lite_decoder_mux_if.sv - master-side and slave-side AHB-Lite signals of the fabric
interface mfp_ahb_lite_decoder_mux_if #(
    parameter int N_SLAVES = 5
) ();

    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [31:0]            HRDATA;
    logic                   HREADY;
    logic                   HRESP;

    logic [N_SLAVES-1:0]    S_HSEL;
    logic [N_SLAVES-1:0]    S_HREADYOUT;
    logic [N_SLAVES*32-1:0] S_HRDATA;
    logic [N_SLAVES-1:0]    S_HRESP;

    // Core view of the bus
    modport master (
        output HADDR, HTRANS, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    // Fabric view: target of the core, and driver of the per-slave selects
    modport slave (
        input  HADDR, HTRANS, HWRITE,
        output HRDATA, HREADY, HRESP,
        output S_HSEL,
        input  S_HREADYOUT, S_HRDATA, S_HRESP
    );

endinterface

// File: rtl/mfp_ahb_lite_default_slave.sv
// rtl/mfp_ahb_lite_default_slave.sv - two-cycle ERROR responder for unmapped accesses plus error capture
module mfp_ahb_lite_default_slave
    import mfp_ahb_lite_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     hready,
    input  logic                     miss,
    input  logic [1:0]               htrans,
    input  logic [31:0]              haddr,
    input  logic                     hwrite,
    input  logic                     err_clr,
    output logic                     ds_hready,
    output logic                     ds_hresp,
    output logic [31:0]              err_addr,
    output logic                     err_write,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    ds_state_t state;
    ds_state_t state_nxt;
    logic      new_err;
    logic      err_start;

    assign new_err = hready & miss & htrans_active(htrans);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs depend on state only, so the HREADY feedback through the top never loops
    always_comb begin
        ds_hready = 1'b1;
        ds_hresp  = HRESP_OKAY;
        case (state)
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = HRESP_ERROR;
            end
            DS_ERR2: ds_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        err_start = 1'b0;
        case (state)
            DS_IDLE: begin
                if (new_err) begin
                    err_start = 1'b1;
                    state_nxt = DS_ERR1;
                end
            end
            DS_ERR1: state_nxt = DS_ERR2;
            DS_ERR2: begin
                if (new_err) begin
                    err_start = 1'b1;
                    state_nxt = DS_ERR1;
                end else begin
                    state_nxt = DS_IDLE;
                end
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    // A fresh error outranks a clear so the capture is never lost
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_addr  <= '0;
            err_write <= 1'b0;
            err_cnt   <= '0;
        end else if (err_start) begin
            err_addr  <= haddr;
            err_write <= hwrite;
            if (err_clr) begin
                err_cnt <= ERR_CNT_WIDTH'(1);
            end else if (!(&err_cnt)) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end else if (err_clr) begin
            err_addr  <= '0;
            err_write <= 1'b0;
            err_cnt   <= '0;
        end
    end

endmodule

// File: rtl/mfp_ahb_lite_decoder_mux.sv
// rtl/mfp_ahb_lite_decoder_mux.sv - parametrised AHB-Lite decoder, data-phase owner tracking and response mux
module mfp_ahb_lite_decoder_mux
    import mfp_ahb_lite_pkg::*;
#(
    parameter int                    N_SLAVES      = 5,
    parameter logic [N_SLAVES*32-1:0] ADDR_BASE    = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] ADDR_MASK    = {N_SLAVES{32'h0}},
    parameter int                    ERR_CNT_WIDTH = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    mfp_ahb_lite_decoder_mux_if.slave bus,
    output logic [31:0]              ERR_ADDR,
    output logic                     ERR_WRITE,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
    input  logic                     ERR_CLR
);

    logic [N_SLAVES-1:0] hit;
    logic [N_SLAVES-1:0] hsel;
    logic                miss;
    logic [N_SLAVES-1:0] sel_r;
    logic                def_r;
    logic [31:0]         hrdata;
    logic                hready;
    logic                hresp;
    logic                ds_hready;
    logic                ds_hresp;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            hit[i] = region_hit(bus.HADDR, ADDR_BASE[32*i +: 32], ADDR_MASK[32*i +: 32]);
        end
    end

    // Isolate the lowest set bit: index 0 wins overlapping regions
    assign hsel       = hit & (~hit + N_SLAVES'(1));
    assign miss       = ~|hit;
    assign bus.S_HSEL = hsel;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_r <= '0;
            def_r <= 1'b0;
        end else if (hready) begin
            sel_r <= hsel;
            def_r <= miss & htrans_active(bus.HTRANS);
        end
    end

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_r[i]) begin
                hrdata = bus.S_HRDATA[32*i +: 32];
                hready = bus.S_HREADYOUT[i];
                hresp  = bus.S_HRESP[i];
            end
        end
        if ((sel_r == '0) && def_r) begin
            hready = ds_hready;
            hresp  = ds_hresp;
        end
    end

    assign bus.HRDATA = hrdata;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;

    mfp_ahb_lite_default_slave #(
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .hready    (hready),
        .miss      (miss),
        .htrans    (bus.HTRANS),
        .haddr     (bus.HADDR),
        .hwrite    (bus.HWRITE),
        .err_clr   (ERR_CLR),
        .ds_hready (ds_hready),
        .ds_hresp  (ds_hresp),
        .err_addr  (ERR_ADDR),
        .err_write (ERR_WRITE),
        .err_cnt   (ERR_CNT)
    );

endmodule

// File: tb/tb_mfp_ahb_lite_decoder_mux.sv
// tb/tb_mfp_ahb_lite_decoder_mux.sv - directed table and sequence bench for the AHB-Lite decoder/mux
module tb_mfp_ahb_lite_decoder_mux;
    import mfp_ahb_lite_pkg::*;

    localparam int NS = 5;
    localparam logic [NS*32-1:0] OVL_BASE = {32'h10401000, DEF_ADDR_BASE[4*32-1:0]};

    typedef struct {
        logic [31:0] haddr;
        logic [4:0]  hsel;
        logic [4:0]  hsel_ovl;
    } tv_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] err_addr, ovl_err_addr;
    logic        err_write, ovl_err_write;
    logic [7:0]  err_cnt, ovl_err_cnt;
    logic        err_clr;
    int          n_total = 0;
    int          n_pass  = 0;
    tv_t         tv[8];

    always #5 clk = ~clk;

    mfp_ahb_lite_decoder_mux_if #(.N_SLAVES(NS)) bus ();
    mfp_ahb_lite_decoder_mux_if #(.N_SLAVES(NS)) bus2 ();

    mfp_ahb_lite_decoder_mux #(
        .N_SLAVES(NS), .ADDR_BASE(DEF_ADDR_BASE), .ADDR_MASK(DEF_ADDR_MASK), .ERR_CNT_WIDTH(8)
    ) dut (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus),
        .ERR_ADDR(err_addr), .ERR_WRITE(err_write), .ERR_CNT(err_cnt), .ERR_CLR(err_clr)
    );

    mfp_ahb_lite_decoder_mux #(
        .N_SLAVES(NS), .ADDR_BASE(OVL_BASE), .ADDR_MASK(DEF_ADDR_MASK), .ERR_CNT_WIDTH(8)
    ) u_ovl (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus2),
        .ERR_ADDR(ovl_err_addr), .ERR_WRITE(ovl_err_write), .ERR_CNT(ovl_err_cnt), .ERR_CLR(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{32'hBFC00010, 5'b00001, 5'b00001};
        tv[1] = '{32'h80000000, 5'b00010, 5'b00010};
        tv[2] = '{32'hBF800000, 5'b00100, 5'b00100};
        tv[3] = '{32'hB0401000, 5'b01000, 5'b01000};
        tv[4] = '{32'hB0401004, 5'b01000, 5'b01000};
        tv[5] = '{32'hB0402000, 5'b10000, 5'b00000};
        tv[6] = '{32'h00000000, 5'b00010, 5'b00010};
        tv[7] = '{32'hB0500000, 5'b00000, 5'b00000};

        bus.HADDR = 32'hB0500000; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
        bus.S_HREADYOUT = '1; bus.S_HRESP = '0;
        bus2.HADDR = 32'hB0500000; bus2.HTRANS = HTRANS_IDLE; bus2.HWRITE = 1'b0;
        bus2.S_HREADYOUT = '1; bus2.S_HRESP = '0; bus2.S_HRDATA = '0;
        for (int i = 0; i < NS; i++) bus.S_HRDATA[32*i +: 32] = 32'hA5A50000 | i;
        err_clr = 1'b0;

        #3;
        chk("rst_hready", bus.HREADY, 1);
        chk("rst_hresp", bus.HRESP, 0);
        chk("rst_hrdata", bus.HRDATA, 0);
        chk("rst_hsel", bus.S_HSEL, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_addr", err_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            bus.HADDR = tv[i].haddr;
            bus2.HADDR = tv[i].haddr;
            #1;
            chk($sformatf("hsel[%0d]", i), bus.S_HSEL, tv[i].hsel);
            chk($sformatf("hsel_ovl[%0d]", i), bus2.S_HSEL, tv[i].hsel_ovl);
            step();
        end

        // Single read to slave 0, response muxed in the next cycle
        bus.HADDR = 32'hBFC00010; bus.HTRANS = HTRANS_NONSEQ; #1;
        chk("s0_hsel", bus.S_HSEL, 5'b00001);
        step();
        bus.HTRANS = HTRANS_IDLE; bus.HADDR = 32'hB0500000; #1;
        chk("s0_hrdata", bus.HRDATA, 32'hA5A50000);
        chk("s0_hready", bus.HREADY, 1);
        bus.S_HREADYOUT[0] = 1'b0; #1;
        chk("s0_hready_follow", bus.HREADY, 0);
        bus.S_HREADYOUT[0] = 1'b1;
        step();
        chk("idle_hrdata", bus.HRDATA, 0);

        // Back-to-back with two wait states from slave 1
        bus.HADDR = 32'h80000000; bus.HTRANS = HTRANS_NONSEQ; #1;
        chk("b2b_hsel1", bus.S_HSEL, 5'b00010);
        step();
        bus.HADDR = 32'hB0401000; bus.S_HREADYOUT[1] = 1'b0; #1;
        chk("b2b_hsel3", bus.S_HSEL, 5'b01000);
        chk("b2b_ws1", bus.HREADY, 0);
        step();
        chk("b2b_ws2", bus.HREADY, 0);
        chk("b2b_hold_data", bus.HRDATA, 32'hA5A50001);
        step();
        bus.S_HREADYOUT[1] = 1'b1; #1;
        chk("b2b_rdy", bus.HREADY, 1);
        chk("b2b_data1", bus.HRDATA, 32'hA5A50001);
        step();
        bus.HTRANS = HTRANS_IDLE; bus.HADDR = 32'hB0500000; #1;
        chk("b2b_data3", bus.HRDATA, 32'hA5A50003);
        step();

        // Unmapped write gets a two-cycle ERROR
        bus.HADDR = 32'hB0500000; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; #1;
        chk("err_hsel", bus.S_HSEL, 0);
        step();
        bus.HTRANS = HTRANS_IDLE; bus.HADDR = 32'h00000000; bus.HWRITE = 1'b0; #1;
        chk("err1_hready", bus.HREADY, 0);
        chk("err1_hresp", bus.HRESP, 1);
        chk("err_addr", err_addr, 32'hB0500000);
        chk("err_write", err_write, 1);
        chk("err_cnt1", err_cnt, 1);
        step();
        chk("err2_hready", bus.HREADY, 1);
        chk("err2_hresp", bus.HRESP, 1);
        step();
        chk("post_err_hready", bus.HREADY, 1);
        chk("post_err_hresp", bus.HRESP, 0);

        // IDLE to an unmapped region is a zero-wait OKAY
        bus.HADDR = 32'hB0500000; bus.HTRANS = HTRANS_IDLE;
        step();
        chk("idle_unm_hready", bus.HREADY, 1);
        chk("idle_unm_hresp", bus.HRESP, 0);
        chk("idle_unm_cnt", err_cnt, 1);

        // Continuous unmapped NONSEQs: one error every two cycles until saturation
        bus.HTRANS = HTRANS_NONSEQ;
        for (int c = 1; c <= 600; c++) begin
            step();
            if (c == 505) chk("cnt_254", err_cnt, 254);
        end
        chk("cnt_sat", err_cnt, 255);
        chk("sat_write", err_write, 0);
        bus.HTRANS = HTRANS_IDLE;
        step();
        chk("drain_hready", bus.HREADY, 1);
        chk("drain_hresp", bus.HRESP, 0);

        // Clear coinciding with a new error: capture wins
        bus.HADDR = 32'hB0500100; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; err_clr = 1'b1;
        step();
        err_clr = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
        chk("clr_new_cnt", err_cnt, 1);
        chk("clr_new_addr", err_addr, 32'hB0500100);
        chk("clr_new_write", err_write, 1);
        step();
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_cnt", err_cnt, 0);
        chk("clr_addr", err_addr, 0);
        chk("clr_write", err_write, 0);

        // Asynchronous reset while in ERR1
        bus.HADDR = 32'hB0500000; bus.HTRANS = HTRANS_NONSEQ;
        step();
        bus.HTRANS = HTRANS_IDLE; #1;
        chk("pre_rst_hready", bus.HREADY, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hready", bus.HREADY, 1);
        chk("async_rst_hresp", bus.HRESP, 0);
        chk("async_rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_hready", bus.HREADY, 1);
        chk("ovl_no_err", ovl_err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_lite_decoder_mux.md
Name: mfp_ahb_lite_decoder_mux

Overview:
Parametrised AHB-Lite single-master interconnect fabric that replaces fixed 5-device decode/select/mux logic with N_SLAVES configurable regions.
- Decodes HADDR against per-slave base/mask pairs and drives per-slave HSEL.
- Tracks the data-phase owner and multiplexes HRDATA/HRESP/HREADYOUT from that slave only.
- Adds a built-in default slave that returns a two-cycle AHB ERROR for unmapped accesses, plus error capture registers.
- Sits between the MIPS core AHB master port and all memory/peripheral slaves.

Parameters:
N_SLAVES, 5, number of attached slaves (1..16); index 0 has highest decode priority.
ADDR_BASE, {N_SLAVES{32'h0}} packed N_SLAVES*32, per-slave base; slot i = bits [32*i+31:32*i].
ADDR_MASK, {N_SLAVES{32'h0}} packed N_SLAVES*32, per-slave compare mask; hit_i = ((HADDR & MASK_i) == (BASE_i & MASK_i)).
ERR_CNT_WIDTH, 8, width of saturating unmapped-access counter.

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  32  master address
HTRANS  in  2  master transfer type
HWRITE  in  1  master direction (captured on error only)
HRDATA  out  32  read data to master
HREADY  out  1  ready to master; also broadcast to slaves as their HREADY input
HRESP  out  1  response to master
S_HSEL  out  N_SLAVES  address-phase select per slave
S_HREADYOUT  in  N_SLAVES  per-slave ready
S_HRDATA  in  N_SLAVES*32  per-slave read data, packed
S_HRESP  in  N_SLAVES  per-slave response
ERR_ADDR  out  32  HADDR of most recent unmapped NONSEQ/SEQ access
ERR_WRITE  out  1  HWRITE of that access
ERR_CNT  out  ERR_CNT_WIDTH  saturating count of unmapped accesses
ERR_CLR  in  1  synchronous clear of ERR_CNT, ERR_ADDR and ERR_WRITE

Behaviour:
- Reset is asynchronous on HRESETn low. All registers clear: sel_r=0, def_r=0, FSM=IDLE, ERR_*=0.
- Outputs after reset: HREADY=1, HRESP=0, HRDATA=0, S_HSEL=0.
- Address decode is combinational.
  - First-hit priority: S_HSEL[i]=1 only for the lowest i with hit_i.
  - S_HSEL is not gated by HTRANS or HREADY; slaves qualify with HTRANS and HREADY themselves.
  - miss = no hit_i.
- Data-phase register sel_r (N_SLAVES bits, one-hot or zero):
  - On a rising edge with HREADY=1: sel_r <= S_HSEL.
  - def_r <= miss & HTRANS[1] (NONSEQ or SEQ).
  - When HREADY=0, sel_r and def_r hold.
- Response mux:
  - sel_r[i]=1: HRDATA=S_HRDATA[i], HREADY=S_HREADYOUT[i], HRESP=S_HRESP[i].
  - sel_r=0 and def_r=0 (idle, BUSY, or unmapped IDLE): HRDATA=0, HREADY=1, HRESP=0 (zero-wait OKAY).
  - sel_r=0 and def_r=1: the default-slave FSM drives HREADY/HRESP; HRDATA=0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on HREADY & miss & HTRANS[1].
  - In ERR1: HREADY=0, HRESP=1; next state is ERR2 unconditionally.
  - In ERR2: HREADY=1, HRESP=1.
  - ERR2 -> ERR1 if another unmapped NONSEQ/SEQ is presented in the same cycle.
  - ERR2 -> IDLE otherwise (a mapped access proceeds normally next cycle).
- Error capture:
  - On the IDLE/ERR2 -> ERR1 transition, ERR_ADDR <= HADDR and ERR_WRITE <= HWRITE.
  - On the same transition, ERR_CNT increments, saturating at all-ones.
  - ERR_CLR=1 clears all three. If ERR_CLR coincides with a new error, the capture wins: ERR_CNT becomes 1 and ERR_ADDR takes the new address.
- Latency: zero added cycles for mapped slaves; the fabric contains no registered data path.
- HTRANS=IDLE to a mapped region still selects that slave; the slave returns OKAY per protocol.
- Slave wait states: the fabric holds sel_r until that slave's HREADYOUT=1; other slaves see HREADY=0 and do not advance.
- Reset mid-transfer: the FSM and sel_r clear immediately and HREADY returns to 1 asynchronously.

Decomposition:
- Package mfp_ahb_lite_pkg holds:
  - HTRANS constants: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
  - Default-slave state encoding.
  - The default address-map base/mask constants for the 5-slave configuration.
- Sub-module mfp_ahb_lite_default_slave contains the IDLE/ERR1/ERR2 FSM and the error capture registers. The top level keeps decode, sel_r and the mux.

Test Plan:
- Default map with N_SLAVES=5:
  - Bases 0x1FC00000, 0x00000000, 0x1F800000, 0x10401000, 0x10402000.
  - Masks 0x1FC00000, 0x1C000000, 0x1FC00000, 0x1FFFF000, 0x1FFFF000.
  - Stimulus: NONSEQ read HADDR=0xBFC00010 -> S_HSEL=00001; next cycle HRDATA=S_HRDATA[0], HREADY=S_HREADYOUT[0].
- Back-to-back NONSEQ to 0x80000000 then 0xB0401000, with slave 1 inserting 2 wait states:
  - S_HSEL=00010 then 01000.
  - HREADY=0 for 2 cycles; sel_r stays 00010 until slave 1 is ready; then HRDATA switches to slave 3.
- NONSEQ write to unmapped 0xB0500000:
  - Next cycle HREADY=0, HRESP=1; following cycle HREADY=1, HRESP=1.
  - ERR_ADDR=0xB0500000, ERR_WRITE=1, ERR_CNT=1.
- IDLE to 0xB0500000 -> HREADY=1, HRESP=0, ERR_CNT unchanged.
- Overlap (slave 4 base set equal to slave 3) with access to 0xB0401004 -> S_HSEL=01000 (lowest index wins).
- Stress: 300 consecutive unmapped NONSEQs -> ERR_CNT saturates at 255. ERR_CLR coinciding with a new error -> ERR_CNT=1. HRESETn low during ERR1 -> HREADY=1, HRESP=0 immediately.
